// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART receiver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, LSB first, mid-bit sampling on the system clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid
);

  localparam int CNT_W = $clog2(TICKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((TICKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t           state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     data_q, data_d;
  logic                     valid_q, valid_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (cnt_q == HALF_CNT) state_d = rx_s ? IDLE : DATA;
      DATA:  if (cnt_q == FULL_CNT && idx_q == LAST_IDX) state_d = STOP;
      STOP:  if (cnt_q == FULL_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter always restarts at zero on each sample point, so the next
  // sample lands one full bit period later, i.e. mid-bit again.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : randomized self-checking bench for uart_rx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int T       = 87;
  localparam int EXP_LAT = (19 * T) / 2 + 2;  // 9.5 bit periods + sync delay
  localparam int LAT_TOL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  int         got_t[$];

  uart_rx #(
    .TICKS_PER_BIT (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference capture: every valid cycle records the byte and when it came.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit with_stop, output int fall);
    fall = cyc;
    hold(1'b0, T);
    for (int i = 0; i < 8; i++) hold(b[i], T);
    if (with_stop) hold(1'b1, T);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_log();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 00", data_out);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b expected 0", valid);
    end
    reset = 1'b1;
    clear_log();
    repeat (500) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_no_valid: got %0d pulses expected 0", got_q.size());
    end
  endtask

  task automatic test_single();
    int fall;
    clear_log();
    send_frame(8'h93, 1'b1, fall);
    repeat (2 * T) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL single_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() >= 1) begin
      n_cmp++;
      if (got_q[0] !== 8'h93) begin
        n_err++;
        $display("FAIL single_data: got %h expected 93", got_q[0]);
      end
      n_cmp++;
      if (got_t[0] - fall < EXP_LAT - LAT_TOL || got_t[0] - fall > EXP_LAT + LAT_TOL) begin
        n_err++;
        $display("FAIL single_latency: got %0d expected %0d +/- %0d",
                 got_t[0] - fall, EXP_LAT, LAT_TOL);
      end
    end
    n_cmp++;
    if (data_out !== 8'h93) begin
      n_err++;
      $display("FAIL single_hold: got %h expected 93", data_out);
    end
  endtask

  task automatic test_missing_stop();
    int fall;
    clear_log();
    send_frame(8'h12, 1'b0, fall);
    rx = 1'b0;
    repeat (T / 2 + 40) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL nostop_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() >= 1) begin
      n_cmp++;
      if (got_q[0] !== 8'h12) begin
        n_err++;
        $display("FAIL nostop_data: got %h expected 12", got_q[0]);
      end
    end
    do_reset();
  endtask

  task automatic test_glitch();
    int fall;
    clear_log();
    hold(1'b0, 20);
    hold(1'b1, 300);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_no_valid: got %0d pulses expected 0", got_q.size());
    end
    send_frame(8'hA5, 1'b1, fall);
    repeat (T) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL glitch_next_frame: got %0d pulses first %h expected 1 pulse A5",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_mid_reset();
    int fall;
    clear_log();
    hold(1'b0, T);
    for (int i = 0; i < 4; i++) hold(1'b1, T);
    hold(1'b1, T / 2);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5 * T) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_no_valid: got %0d pulses expected 0", got_q.size());
    end
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_data: got %h expected 00", data_out);
    end
    send_frame(8'h3C, 1'b1, fall);
    repeat (T) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      n_err++;
      $display("FAIL midreset_next_frame: got %0d pulses first %h expected 1 pulse 3C",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    int fall;
    logic [7:0] b;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      do_reset();
      clear_log();
      send_frame(b, 1'b1, fall);
      repeat (T) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== b) begin
        n_err++;
        $display("FAIL random_%0d: got %0d pulses first %h expected 1 pulse %h",
                 k, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fall0, fall1;
    do_reset();
    clear_log();
    send_frame(8'h55, 1'b1, fall0);
    send_frame(8'hAA, 1'b1, fall1);
    repeat (T) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d pulses expected 2", got_q.size());
    end
    if (got_q.size() == 2) begin
      n_cmp++;
      if (got_q[0] !== 8'h55 || got_q[1] !== 8'hAA) begin
        n_err++;
        $display("FAIL b2b_data: got %h %h expected 55 AA", got_q[0], got_q[1]);
      end
      n_cmp++;
      if (got_t[1] - got_t[0] != fall1 - fall0) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d expected %0d",
                 got_t[1] - got_t[0], fall1 - fall0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_missing_stop();
    test_glitch();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
